phase_accumulator: RTL and testbench

//  Time-multiplexed per-voice phase generator. It feeds the waveform generator's 13-bit phase input.
//  One voice is serviced per clock, round-robin over NUM_VOICES voices.
//  - Per-voice frequency words and accumulators live in block RAM.
//  - Output is a (voice, phase, valid) stream, one voice per clock.

---
 rtl/phase_accumulator_if.sv | 49 ++++
 rtl/phase_accumulator.sv | 130 +++++++++++++
 tb/tb_phase_accumulator.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/phase_accumulator_if.sv
// phase_accumulator_if: frequency-write, sync and phase-stream bundle.
// i_PhaseMod exists only when OCTANE_PHASE_MOD_EN is defined.
interface phase_accumulator_if #(
  parameter int NUM_VOICES  = 32,
  parameter int ACC_WIDTH   = 24,
  parameter int PHASE_WIDTH = 13
);
  localparam int VW = $clog2(NUM_VOICES);

  logic                   i_FreqWriteEn;
  logic [VW-1:0]          i_FreqWriteVoice;
  logic [ACC_WIDTH-1:0]   i_FreqWriteValue;
  logic                   i_SyncEn;
  logic [VW-1:0]          i_SyncVoice;
`ifdef OCTANE_PHASE_MOD_EN
  logic [PHASE_WIDTH-1:0] i_PhaseMod;
`endif
  logic                   o_Valid;
  logic [VW-1:0]          o_Voice;
  logic [PHASE_WIDTH-1:0] o_Phase;

  modport master (
    output i_FreqWriteEn,
    output i_FreqWriteVoice,
    output i_FreqWriteValue,
    output i_SyncEn,
    output i_SyncVoice,
`ifdef OCTANE_PHASE_MOD_EN
    output i_PhaseMod,
`endif
    input  o_Valid,
    input  o_Voice,
    input  o_Phase
  );

  modport slave (
    input  i_FreqWriteEn,
    input  i_FreqWriteVoice,
    input  i_FreqWriteValue,
    input  i_SyncEn,
    input  i_SyncVoice,
`ifdef OCTANE_PHASE_MOD_EN
    input  i_PhaseMod,
`endif
    output o_Valid,
    output o_Voice,
    output o_Phase
  );
endinterface

// File: rtl/phase_accumulator.sv
// phase_accumulator: round-robin per-voice phase generator, one voice/clk.
// Define OCTANE_PHASE_MOD_EN to add a per-sample phase offset input.
module phase_accumulator #(
  parameter int NUM_VOICES  = 32,
  parameter int ACC_WIDTH   = 24,
  parameter int PHASE_WIDTH = 13
) (
  input logic i_Clock,
  input logic i_Reset,
  phase_accumulator_if.slave bus
);
  localparam int VW = $clog2(NUM_VOICES);
  localparam logic [VW-1:0] LAST = VW'(NUM_VOICES - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t state;
  state_t state_nxt;
  logic   clr_wr;
  logic   run_s1;

  logic [VW-1:0]        index;
  logic [ACC_WIDTH-1:0] acc_mem  [NUM_VOICES];
  logic [ACC_WIDTH-1:0] freq_mem [NUM_VOICES];
  logic [NUM_VOICES-1:0] pending;

  logic                 s2_valid;
  logic [VW-1:0]        s2_voice;
  logic [ACC_WIDTH-1:0] s2_acc;
  logic [ACC_WIDTH-1:0] s2_freq;

  logic                   sync_hit;
  logic                   zero;
  logic [ACC_WIDTH-1:0]   acc_new;
  logic [PHASE_WIDTH-1:0] acc_top;
  logic [PHASE_WIDTH-1:0] phase_new;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state <= CLEAR;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR:   if (index == LAST) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    clr_wr = 1'b0;
    run_s1 = 1'b0;
    unique case (state)
      CLEAR:   clr_wr = !i_Reset;
      RUN:     run_s1 = !i_Reset;
      default: ;
    endcase
  end

  // Index walks CLEAR addresses, then doubles as the RUN voice counter.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) index <= '0;
    else         index <= index + 1'b1;
  end

  always_ff @(posedge i_Clock) begin
    if (clr_wr)
      acc_mem[index] <= '0;
    else if (s2_valid && !i_Reset)
      acc_mem[s2_voice] <= acc_new;
  end

  always_ff @(posedge i_Clock) begin
    if (clr_wr)
      freq_mem[index] <= '0;
    else if (run_s1 && bus.i_FreqWriteEn)
      freq_mem[bus.i_FreqWriteVoice] <= bus.i_FreqWriteValue;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= run_s1;
      s2_voice <= index;
      s2_acc   <= acc_mem[index];
      s2_freq  <= freq_mem[index];
    end
  end

  // A sync landing in its own stage-2 cycle zeroes this pass and the next.
  always_comb begin
    sync_hit = bus.i_SyncEn && (bus.i_SyncVoice == s2_voice);
    zero     = pending[s2_voice] || sync_hit;
    acc_new  = zero ? '0 : s2_acc + s2_freq;
    acc_top  = acc_new[ACC_WIDTH-1 -: PHASE_WIDTH];
`ifdef OCTANE_PHASE_MOD_EN
    phase_new = acc_top + bus.i_PhaseMod;
`else
    phase_new = acc_top;
`endif
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      pending <= '0;
    end else begin
      if (s2_valid)
        pending[s2_voice] <= 1'b0;
      if (run_s1 && bus.i_SyncEn)
        pending[bus.i_SyncVoice] <= 1'b1;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      bus.o_Valid <= 1'b0;
      bus.o_Voice <= '0;
      bus.o_Phase <= '0;
    end else begin
      bus.o_Valid <= s2_valid;
      if (s2_valid) begin
        bus.o_Voice <= s2_voice;
        bus.o_Phase <= phase_new;
      end
    end
  end
endmodule

// File: tb/tb_phase_accumulator.sv
// tb_phase_accumulator: directed stimulus, queued expectations, stream monitor.
// Builds with or without OCTANE_PHASE_MOD_EN.
module tb_phase_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  phase_accumulator_if #(32, 24, 13) bus ();

  phase_accumulator #(
    .NUM_VOICES (32),
    .ACC_WIDTH  (24),
    .PHASE_WIDTH(13)
  ) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q [$];

  logic [23:0] m_acc  [32];
  logic [23:0] m_freq [32];
  logic [23:0] m_lat  [32];
  bit          m_pend [32];
  int          k = 0;
  logic [12:0] pm = '0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Spec-level model of one clock edge: stage 2 then stage 1.
  task automatic model(input bit r, input bit fwe, input int fwv,
                       input logic [23:0] fwval, input bit se, input int sv);
    int v1, v2;
    bit z;
    logic [23:0] nv;
    logic [12:0] ph;
    if (r) begin
      k = 0;
      for (int i = 0; i < 32; i++) begin
        m_acc[i] = '0; m_freq[i] = '0; m_lat[i] = '0; m_pend[i] = 0;
      end
    end else begin
      k++;
      if (k >= 34) begin
        v2 = (k - 34) % 32;
        z  = m_pend[v2] || (se && sv == v2);
        nv = z ? 24'h0 : m_acc[v2] + m_lat[v2];
        m_acc[v2]  = nv;
        m_pend[v2] = 0;
        ph = nv[23:11];
`ifdef OCTANE_PHASE_MOD_EN
        ph = ph + pm;
`endif
        exp_q.push_back({v2[4:0], ph});
      end
      if (k >= 33) begin
        v1 = (k - 33) % 32;
        m_lat[v1] = m_freq[v1];
        if (fwe) m_freq[fwv] = fwval;
        if (se)  m_pend[sv]  = 1;
      end
    end
  endtask

  task automatic tick(input bit r, input bit fwe, input int fwv,
                      input logic [23:0] fwval, input bit se, input int sv);
    rst = r;
    bus.i_FreqWriteEn    = fwe;
    bus.i_FreqWriteVoice = 5'(fwv);
    bus.i_FreqWriteValue = fwval;
    bus.i_SyncEn         = se;
    bus.i_SyncVoice      = 5'(sv);
`ifdef OCTANE_PHASE_MOD_EN
    bus.i_PhaseMod = pm;
`endif
    model(r, fwe, fwv, fwval, se, sv);
    @(posedge clk);
    #3;
    rst = 1'b0;
    bus.i_FreqWriteEn = 1'b0;
    bus.i_SyncEn      = 1'b0;
  endtask

  task automatic idle();
    tick(0, 0, 0, 24'h0, 0, 0);
  endtask

  task automatic next_sample(input int v, output int ph);
    int n = 0;
    bit found = 0;
    do begin
      idle();
      n++;
      found = (bus.o_Valid === 1'b1) && (bus.o_Voice == 5'(v));
    end while (!found && n < 70);
    if (!found) begin
      total++; bad++;
      $display("FAIL timeout_voice%0d: got none want sample", v);
    end
    ph = int'(bus.o_Phase);
  endtask

  task automatic reset_and_wait(input string name);
    int n = 0;
    tick(1, 0, 0, 24'h0, 0, 0);
    chk({name, "_valid_after_rst"}, int'(bus.o_Valid), 0);
    chk({name, "_phase_after_rst"}, int'(bus.o_Phase), 0);
    while (bus.o_Valid !== 1'b1 && n < 100) begin
      n++;
      idle();
    end
    chk({name, "_valid_low_clks"}, n, 34);
    chk({name, "_first_voice"}, int'(bus.o_Voice), 0);
    chk({name, "_first_phase"}, int'(bus.o_Phase), 0);
  endtask

  // Monitor: every presented sample consumes one queued expectation.
  initial begin
    logic [17:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (bus.o_Valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL stream_extra: got v=%0d p=%h want no sample",
                   bus.o_Voice, bus.o_Phase);
        end else begin
          e = exp_q.pop_front();
          if ({bus.o_Voice, bus.o_Phase} !== e) begin
            bad++;
            $display("FAIL stream: got v=%0d p=%h want v=%0d p=%h",
                     bus.o_Voice, bus.o_Phase, e[17:13], e[12:0]);
          end
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++; bad++;
        $display("FAIL stream_missing: got valid=%b want v=%0d p=%h",
                 bus.o_Valid, e[17:13], e[12:0]);
      end
    end
  end

  initial begin
    int ph;
    int orv;
    bus.i_FreqWriteEn = 0; bus.i_FreqWriteVoice = '0;
    bus.i_FreqWriteValue = '0; bus.i_SyncEn = 0; bus.i_SyncVoice = '0;
`ifdef OCTANE_PHASE_MOD_EN
    bus.i_PhaseMod = '0;
`endif
    reset_and_wait("t1");
    idle();
    chk("t1_voice_inc", int'(bus.o_Voice), 1);
    idle();
    chk("t1_voice_inc2", int'(bus.o_Voice), 2);

    next_sample(10, ph);
    tick(0, 1, 3, 24'h000800, 0, 0);
    tick(0, 1, 5, 24'h800000, 0, 0);
    next_sample(3, ph); chk("t2_v3_p1", ph, 1);
    next_sample(5, ph); chk("t3_v5_p1", ph, 'h1000);
    next_sample(3, ph); chk("t2_v3_p2", ph, 2);
    next_sample(5, ph); chk("t3_v5_p2", ph, 'h0000);
    next_sample(3, ph); chk("t2_v3_p3", ph, 3);
    next_sample(5, ph); chk("t3_v5_p3", ph, 'h1000);

    next_sample(20, ph);
    tick(0, 0, 0, 24'h0, 1, 3);
    next_sample(3, ph); chk("t4_sync_zero", ph, 0);
    next_sample(3, ph); chk("t4_sync_resume", ph, 1);
    next_sample(2, ph);
    tick(0, 0, 0, 24'h0, 1, 3);
    chk("t4_s2_voice", int'(bus.o_Voice), 3);
    chk("t4_s2_zero1", int'(bus.o_Phase), 0);
    next_sample(3, ph); chk("t4_s2_zero2", ph, 0);
    next_sample(3, ph); chk("t4_s2_resume", ph, 1);

    next_sample(20, ph);
    tick(0, 1, 9, 24'h002000, 1, 9);
    next_sample(9, ph); chk("t5_fw_sync_zero", ph, 0);
    next_sample(9, ph); chk("t5_fw_sync_step", ph, 4);

    next_sample(20, ph);
    tick(0, 1, 7, 24'h001000, 0, 0);
    next_sample(7, ph); chk("t5_v7_old_a", ph, 2);
    next_sample(5, ph);
    tick(0, 1, 7, 24'h004000, 0, 0);
    next_sample(7, ph); chk("t5_v7_old_b", ph, 4);
    next_sample(7, ph); chk("t5_v7_new", ph, 12);

    next_sample(12, ph);
    reset_and_wait("t6");
    orv = 0;
    for (int i = 0; i < 64; i++) begin
      idle();
      orv |= int'(bus.o_Phase);
    end
    chk("t6_phases_zero", orv, 0);

    next_sample(0, ph);
    tick(0, 1, 3, 24'h000800, 0, 0);
`ifdef OCTANE_PHASE_MOD_EN
    pm = 13'h1FFF;
    next_sample(3, ph); chk("t7_mod_wrap", ph, 0);
    pm = 13'h0000;
    next_sample(3, ph); chk("t7_acc_adv", ph, 2);
`else
    next_sample(3, ph); chk("t7_nomod_p1", ph, 1);
    next_sample(3, ph); chk("t7_nomod_p2", ph, 2);
`endif
    idle();
    idle();
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
